// File: rtl/rv_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_hazard_ctrl
// Purpose  : Pipeline hazard controller for the 5-stage RV32 core. Shadows the
//            destination tags of the EX/MEM/WB stages. Produces registered
//            EX-stage operand forward selects, load-use bubbles, branch-redirect
//            flushes and data-memory wait-state freezes.
// Ports    : clk, rst_n (sync, active-low)
//            id_*            - decoded ID-stage instruction information
//            ex_branch_taken - EX redirects the PC
//            mem_busy        - data memory wait state
//            forward_ex_rs*  - EX operand select (11 MEM, 10 WB, 0x regfile)
//            stall_*/flush_* - pipeline register hold / bubble enables
//            load_use_cnt, flush_cnt - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module rv_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_reg_wr,
    input  logic                      id_mem_rd,
    input  logic                      ex_branch_taken,
    input  logic                      mem_busy,
    output logic [1:0]                forward_ex_rs1,
    output logic [1:0]                forward_ex_rs2,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      stall_mem,
    output logic                      flush_id,
    output logic                      flush_ex,
    output logic [CNT_WIDTH-1:0]      load_use_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    // Shadow tag slots
    logic                      ex_valid_q,  mem_valid_q,  wb_valid_q;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q,     mem_rd_q,     wb_rd_q;
    logic                      ex_wr_q,     mem_wr_q,     wb_wr_q;
    logic                      ex_ld_q,     mem_ld_q,     wb_ld_q;

    logic [1:0]                fwd_rs1_q, fwd_rs2_q;
    logic [1:0]                fwd_rs1_d, fwd_rs2_d;
    logic [CNT_WIDTH-1:0]      load_use_cnt_q, flush_cnt_q;

    logic ex_prod, mem_prod;
    logic rs1_hit_ex, rs2_hit_ex, rs1_hit_mem, rs2_hit_mem;
    logic freeze, redirect, load_use;

    // The WB slot is shadowed for completeness but never forwards from: the
    // register file writes before it reads, so a WB producer is already
    // visible to the ID read.
    logic unused_wb_tag;
    assign unused_wb_tag = ^{wb_valid_q, wb_rd_q, wb_wr_q, wb_ld_q, mem_ld_q};

    always_comb begin
        ex_prod     = ex_valid_q  && ex_wr_q  && (ex_rd_q  != REG_ZERO);
        mem_prod    = mem_valid_q && mem_wr_q && (mem_rd_q != REG_ZERO);
        rs1_hit_ex  = id_rs1_used && (id_rs1_addr != REG_ZERO) && ex_prod  && (id_rs1_addr == ex_rd_q);
        rs2_hit_ex  = id_rs2_used && (id_rs2_addr != REG_ZERO) && ex_prod  && (id_rs2_addr == ex_rd_q);
        rs1_hit_mem = id_rs1_used && (id_rs1_addr != REG_ZERO) && mem_prod && (id_rs1_addr == mem_rd_q);
        rs2_hit_mem = id_rs2_used && (id_rs2_addr != REG_ZERO) && mem_prod && (id_rs2_addr == mem_rd_q);

        // Priority: freeze over redirect over load-use
        freeze   = mem_busy;
        redirect = ex_branch_taken && !mem_busy;
        load_use = id_valid && ex_ld_q && (rs1_hit_ex || rs2_hit_ex) && !mem_busy && !ex_branch_taken;

        // An EX producer will sit in MEM when the consumer reaches EX
        fwd_rs1_d = rs1_hit_ex ? 2'b11 : (rs1_hit_mem ? 2'b10 : 2'b00);
        fwd_rs2_d = rs2_hit_ex ? 2'b11 : (rs2_hit_mem ? 2'b10 : 2'b00);
    end

    assign stall_if  = freeze || load_use;
    assign stall_id  = freeze || load_use;
    assign stall_ex  = freeze;
    assign stall_mem = freeze;
    assign flush_id  = redirect;
    assign flush_ex  = redirect || load_use;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_wr_q        <= 1'b0;
            ex_ld_q        <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_wr_q       <= 1'b0;
            mem_ld_q       <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_wr_q        <= 1'b0;
            wb_ld_q        <= 1'b0;
            fwd_rs1_q      <= 2'b00;
            fwd_rs2_q      <= 2'b00;
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else if (!freeze) begin
            wb_valid_q  <= mem_valid_q;
            wb_rd_q     <= mem_rd_q;
            wb_wr_q     <= mem_wr_q;
            wb_ld_q     <= mem_ld_q;
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            mem_wr_q    <= ex_wr_q;
            mem_ld_q    <= ex_ld_q;
            // A bubble entering EX carries no producer
            ex_valid_q  <= id_valid && !flush_ex;
            ex_rd_q     <= id_rd_addr;
            ex_wr_q     <= id_reg_wr;
            ex_ld_q     <= id_mem_rd;

            fwd_rs1_q   <= flush_ex ? 2'b00 : fwd_rs1_d;
            fwd_rs2_q   <= flush_ex ? 2'b00 : fwd_rs2_d;

            if (load_use && (load_use_cnt_q != CNT_MAX)) begin
                load_use_cnt_q <= load_use_cnt_q + 1'b1;
            end
            if (redirect && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign forward_ex_rs1 = fwd_rs1_q;
    assign forward_ex_rs2 = fwd_rs2_q;
    assign load_use_cnt   = load_use_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_hazard_ctrl
// Purpose  : Self-checking bench for rv_hazard_ctrl. A small in-flight
//            instruction model predicts every output each cycle; directed
//            instruction sequences add literal expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used, id_reg_wr, id_mem_rd;
    logic        ex_branch_taken, mem_busy;
    logic [1:0]  forward_ex_rs1, forward_ex_rs2;
    logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
    logic [15:0] load_use_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    rv_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .forward_ex_rs1(forward_ex_rs1), .forward_ex_rs2(forward_ex_rs2),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
        .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // In-flight instructions younger-first: [0]=EX, [1]=MEM, [2]=WB
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } inst_t;

    inst_t pipe [3];
    bit [1:0] m_fwd1, m_fwd2;
    int  m_lu_cnt, m_fl_cnt;
    bit  m_ready = 1'b0;

    function automatic bit writes(inst_t t, bit [4:0] r, bit used);
        return used && (r != 5'd0) && t.v && t.wr && (t.rd == r);
    endfunction

    // Distance to the nearest older producer decides where its result lives
    function automatic bit [1:0] sel(bit [4:0] r, bit used);
        for (int d = 0; d < 2; d++)
            if (writes(pipe[d], r, used)) return (d == 0) ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_freeze();
        return mem_busy;
    endfunction
    function automatic bit m_redir();
        return ex_branch_taken && !mem_busy;
    endfunction
    function automatic bit m_lu();
        return !mem_busy && !ex_branch_taken && id_valid && pipe[0].ld &&
               (writes(pipe[0], id_rs1_addr, id_rs1_used) || writes(pipe[0], id_rs2_addr, id_rs2_used));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
            m_fwd1 = 0; m_fwd2 = 0; m_lu_cnt = 0; m_fl_cnt = 0;
            m_ready = 1'b1;
        end else if (!m_freeze()) begin
            bit bubble;
            bubble = m_redir() || m_lu();
            if (m_lu()    && m_lu_cnt < 65535) m_lu_cnt++;
            if (m_redir() && m_fl_cnt < 65535) m_fl_cnt++;
            m_fwd1 = bubble ? 2'b00 : sel(id_rs1_addr, id_rs1_used);
            m_fwd2 = bubble ? 2'b00 : sel(id_rs2_addr, id_rs2_used);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{id_valid && !bubble, id_rd_addr, id_reg_wr, id_mem_rd};
        end
    end

    // Compare process: mid-cycle, against the model
    always @(negedge clk) begin
        if (m_ready) begin
            bit st, rd, lu;
            st = m_freeze(); rd = m_redir(); lu = m_lu();
            check("ctl{sif,sid,sex,smem,fid,fex}",
                  {26'd0, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex},
                  {26'd0, st || lu, st || lu, st, st, rd, rd || lu});
            check("fwd{rs1,rs2}", {28'd0, forward_ex_rs1, forward_ex_rs2}, {28'd0, m_fwd1, m_fwd2});
            check("cnt{lu,flush}", {load_use_cnt, flush_cnt}, {m_lu_cnt[15:0], m_fl_cnt[15:0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inst(input bit [4:0] rd, input bit wr, input bit ld,
                        input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2);
        id_valid = 1'b1; id_rd_addr = rd; id_reg_wr = wr; id_mem_rd = ld;
        id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2; id_rs2_used = u2;
    endtask

    task automatic nop();
        id_valid = 1'b0; id_rd_addr = 0; id_reg_wr = 0; id_mem_rd = 0;
        id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
    endtask

    initial begin
        rst_n = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        nop();
        step(2);
        rst_n = 1'b1;
        #1;
        check("reset fwd", {30'd0, forward_ex_rs1}, 32'd0);
        check("reset stall_if", {31'd0, stall_if}, 32'd0);
        check("reset cnt", {load_use_cnt, flush_cnt}, 32'd0);

        // ALU chain: adjacent, one NOP, two NOPs
        inst(5, 1, 0, 1, 1, 2, 1); step(1);
        inst(6, 1, 0, 5, 1, 1, 1); step(1);
        check("alu adj rs1", {30'd0, forward_ex_rs1}, 32'h3);
        check("alu adj rs2", {30'd0, forward_ex_rs2}, 32'h0);
        nop(); step(3);
        inst(5, 1, 0, 1, 1, 2, 1); step(1);
        nop(); step(1);
        inst(6, 1, 0, 5, 1, 1, 1); step(1);
        check("alu 1nop rs1", {30'd0, forward_ex_rs1}, 32'h2);
        nop(); step(3);
        inst(5, 1, 0, 1, 1, 2, 1); step(1);
        nop(); step(2);
        inst(6, 1, 0, 5, 1, 1, 1); step(1);
        check("alu 2nop rs1", {30'd0, forward_ex_rs1}, 32'h0);
        nop(); step(3);

        // Load-use
        inst(7, 1, 1, 1, 1, 2, 1); step(1);
        inst(8, 1, 0, 7, 1, 7, 1); #1;
        check("lu stalls", {29'd0, stall_if, stall_id, flush_ex}, 32'h7);
        step(1);
        check("lu after bubble", {29'd0, stall_if, stall_id, flush_ex}, 32'h0);
        step(1);
        check("lu fwd", {28'd0, forward_ex_rs1, forward_ex_rs2}, 32'hA);
        check("lu cnt", {16'd0, load_use_cnt}, 32'd1);
        nop(); step(3);

        // x0 producer and unused source
        inst(0, 1, 0, 1, 1, 0, 0); step(1);
        inst(1, 1, 0, 0, 1, 0, 1); #1;
        check("x0 stall", {31'd0, stall_if}, 32'd0);
        step(1);
        check("x0 fwd", {28'd0, forward_ex_rs1, forward_ex_rs2}, 32'h0);
        inst(3, 1, 0, 1, 1, 2, 1); step(1);
        inst(4, 1, 0, 0, 0, 3, 0); step(1);
        check("unused rs2 fwd", {30'd0, forward_ex_rs2}, 32'h0);
        nop(); step(3);

        // Branch beats load-use
        inst(9, 1, 1, 1, 1, 2, 1); step(1);
        inst(10, 1, 0, 9, 1, 0, 0); ex_branch_taken = 1'b1; #1;
        check("br flush/stall", {29'd0, flush_id, flush_ex, stall_if}, 32'h6);
        step(1);
        ex_branch_taken = 1'b0; nop(); #1;
        check("br flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check("br lu_cnt", {16'd0, load_use_cnt}, 32'd1);
        step(3);

        // Freeze with a pending 11 select
        inst(11, 1, 0, 1, 1, 2, 1); step(1);
        inst(12, 1, 0, 11, 1, 0, 0); step(1);
        check("pre-freeze fwd", {30'd0, forward_ex_rs1}, 32'h3);
        inst(13, 1, 0, 12, 1, 0, 0); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("freeze stalls", {28'd0, stall_if, stall_id, stall_ex, stall_mem}, 32'hF);
            check("freeze fwd", {30'd0, forward_ex_rs1}, 32'h3);
            step(1);
        end
        mem_busy = 1'b0; step(1);
        check("resume fwd", {30'd0, forward_ex_rs1}, 32'h3);
        nop(); step(3);

        // Reset in the middle of a load-use
        inst(14, 1, 1, 1, 1, 2, 1); step(1);
        inst(15, 1, 0, 14, 1, 0, 0); #1;
        check("pre-reset lu", {31'd0, stall_if}, 32'd1);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; #1;
        check("post-reset ctl", {26'd0, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex}, 32'd0);
        check("post-reset fwd", {28'd0, forward_ex_rs1, forward_ex_rs2}, 32'd0);
        check("post-reset cnt", {load_use_cnt, flush_cnt}, 32'd0);
        nop(); step(2);

        // Saturate flush_cnt with a continuous redirect
        ex_branch_taken = 1'b1;
        step(65535);
        check("flush_cnt at max", {16'd0, flush_cnt}, 32'hFFFF);
        step(2);
        check("flush_cnt saturated", {16'd0, flush_cnt}, 32'hFFFF);
        ex_branch_taken = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
